// File: rtl/dvi_tx_pkg.sv
// Shared definitions for the DVI transmitter timing controller:
// control tokens, sequencer states, colour-bar palette and timing checks.
package dvi_tx_pkg;

   // {vsync, hsync} control tokens, active-high form before polarity is applied
   localparam logic [1:0] CTRL_NONE  = 2'b00;
   localparam logic [1:0] CTRL_HSYNC = 2'b01;
   localparam logic [1:0] CTRL_VSYNC = 2'b10;

   // Sequencer states
   typedef logic [1:0] state_t;
   localparam state_t ST_IDLE  = 2'd0;
   localparam state_t ST_RUN   = 2'd1;
   localparam state_t ST_DRAIN = 2'd2;

   // Colour-bar palette, {R,G,B}
   localparam logic [23:0] BAR_WHITE   = 24'hFFFFFF;
   localparam logic [23:0] BAR_YELLOW  = 24'hFFFF00;
   localparam logic [23:0] BAR_CYAN    = 24'h00FFFF;
   localparam logic [23:0] BAR_GREEN   = 24'h00FF00;
   localparam logic [23:0] BAR_MAGENTA = 24'hFF00FF;
   localparam logic [23:0] BAR_RED     = 24'hFF0000;
   localparam logic [23:0] BAR_BLUE    = 24'h0000FF;
   localparam logic [23:0] BAR_BLACK   = 24'h000000;

   function automatic logic [23:0] bar_rgb(input logic [2:0] idx);
      case (idx)
         3'd0:    return BAR_WHITE;
         3'd1:    return BAR_YELLOW;
         3'd2:    return BAR_CYAN;
         3'd3:    return BAR_GREEN;
         3'd4:    return BAR_MAGENTA;
         3'd5:    return BAR_RED;
         3'd6:    return BAR_BLUE;
         default: return BAR_BLACK;
      endcase
   endfunction

   // A raster dimension must fit the 12-bit counters
   function automatic bit timing_sum_ok(input int unsigned a, input int unsigned b,
                                        input int unsigned c, input int unsigned d);
      return (a + b + c + d) <= 4095;
   endfunction

endpackage

// File: rtl/dvi_tx_timing_ctrl_delay_line.sv
// Fixed-depth shift register used to align raster control and pattern data
// with the upstream pixel latency. Synchronous reset flushes every stage.
module dvi_tx_delay_line
   import dvi_tx_pkg::*;
#(
   parameter int unsigned DEPTH = 2,
   parameter int unsigned WIDTH = 4
) (
   input  logic             i_clock,
   input  logic             i_reset,
   input  logic [WIDTH-1:0] i_d,
   output logic [WIDTH-1:0] o_q
);

   logic [WIDTH-1:0] r_sr [DEPTH];

   // Shift one stage per clock; reset clears all stages
   always_ff @(posedge i_clock) begin
      if (i_reset) begin
         for (int unsigned i = 0; i < DEPTH; i++) r_sr[i] <= '0;
      end else begin
         r_sr[0] <= i_d;
         for (int unsigned i = 1; i < DEPTH; i++) r_sr[i] <= r_sr[i-1];
      end
   end

   assign o_q = r_sr[DEPTH-1];

endmodule

// File: rtl/dvi_tx_timing_ctrl.sv
// DVI transmitter video timing sequencer: raster counters, pixel fetch,
// latency-aligned den/data/ctrl for the three TMDS encoders.
// Optional build macro DVI_TX_TEST_PATTERN_EN adds i_test_pattern and an
// internal 8-bar colour generator.
module dvi_tx_timing_ctrl
   import dvi_tx_pkg::*;
#(
   parameter int unsigned H_ACTIVE = 1280,
   parameter int unsigned H_FP     = 110,
   parameter int unsigned H_SYNC   = 40,
   parameter int unsigned H_BP     = 220,
   parameter int unsigned V_ACTIVE = 720,
   parameter int unsigned V_FP     = 5,
   parameter int unsigned V_SYNC   = 5,
   parameter int unsigned V_BP     = 20,
   parameter int unsigned HS_POL   = 1,
   parameter int unsigned VS_POL   = 1,
   parameter int unsigned PIX_LAT  = 2
) (
   input  logic        i_clock,
   input  logic        i_reset,
   input  logic        i_enable,
`ifdef DVI_TX_TEST_PATTERN_EN
   input  logic        i_test_pattern,
`endif
   output logic        o_pix_req,
   output logic [11:0] o_pix_x,
   output logic [11:0] o_pix_y,
   input  logic [23:0] i_pix_rgb,
   input  logic        i_pix_valid,
   output logic        o_enc_den,
   output logic [7:0]  o_enc_data_b,
   output logic [7:0]  o_enc_data_g,
   output logic [7:0]  o_enc_data_r,
   output logic [1:0]  o_enc_ctrl_b,
   output logic [1:0]  o_enc_ctrl_g,
   output logic [1:0]  o_enc_ctrl_r,
   output logic        o_frame_start,
   output logic        o_underflow,
   output logic        o_busy
);

   localparam int unsigned H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
   localparam int unsigned V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

   localparam logic [11:0] H_ACT12  = 12'(H_ACTIVE);
   localparam logic [11:0] H_SB12   = 12'(H_ACTIVE + H_FP);
   localparam logic [11:0] H_SE12   = 12'(H_ACTIVE + H_FP + H_SYNC);
   localparam logic [11:0] H_LAST12 = 12'(H_TOTAL - 1);
   localparam logic [11:0] V_ACT12  = 12'(V_ACTIVE);
   localparam logic [11:0] V_SB12   = 12'(V_ACTIVE + V_FP);
   localparam logic [11:0] V_SE12   = 12'(V_ACTIVE + V_FP + V_SYNC);
   localparam logic [11:0] V_LAST12 = 12'(V_TOTAL - 1);
   localparam logic [3:0]  DRAIN_LAST = 4'(PIX_LAT - 1);

   localparam logic       HS_ACT    = (HS_POL != 0);
   localparam logic       VS_ACT    = (VS_POL != 0);
   localparam logic [1:0] CTRL_IDLE = {!VS_ACT, !HS_ACT};

   if (!timing_sum_ok(H_ACTIVE, H_FP, H_SYNC, H_BP) ||
       !timing_sum_ok(V_ACTIVE, V_FP, V_SYNC, V_BP) ||
       (PIX_LAT < 1) || (PIX_LAT > 8)) begin : g_bad_cfg
      $error("dvi_tx_timing_ctrl: raster totals exceed 4095 or PIX_LAT outside 1..8");
   end

   state_t      r_state;
   logic [11:0] r_h, r_v, r_px, r_py;
   logic [3:0]  r_drain;
   logic        r_den, r_fs, r_uf;
   logic [1:0]  r_ctrl;
   logic [23:0] r_rgb;

   logic        w_run, w_den, w_hs, w_vs, w_fs, w_req;
   logic        w_d_den, w_d_hs, w_d_vs, w_d_fs;
   logic [1:0]  w_tok;
   logic [23:0] w_src_rgb;
   logic        w_src_ok;

   assign w_run = (r_state == ST_RUN);
   assign w_den = w_run && (r_h < H_ACT12) && (r_v < V_ACT12);
   assign w_hs  = (r_h >= H_SB12) && (r_h < H_SE12);
   assign w_vs  = (r_v >= V_SB12) && (r_v < V_SE12);
   assign w_fs  = w_run && (r_h == 12'd0) && (r_v == 12'd0);

`ifdef DVI_TX_TEST_PATTERN_EN
   logic        r_tp;
   logic        w_tp_frame, w_d_pat;
   logic [2:0]  w_bar_idx;
   logic [23:0] w_pat_rgb;

   // The pattern select applies from the first pixel of the frame it is sampled on
   assign w_tp_frame = w_fs ? i_test_pattern : r_tp;
   assign w_req      = w_den && !w_tp_frame;
   assign w_bar_idx  = 3'((32'(r_h) * 32'd8) / H_ACTIVE);

   // Latch the pattern select at each frame start
   always_ff @(posedge i_clock) begin
      if (i_reset)   r_tp <= 1'b0;
      else if (w_fs) r_tp <= i_test_pattern;
   end

   dvi_tx_delay_line #(.DEPTH(PIX_LAT), .WIDTH(25)) u_pat_dly (
      .i_clock (i_clock),
      .i_reset (i_reset),
      .i_d     ({w_tp_frame && w_den, bar_rgb(w_bar_idx)}),
      .o_q     ({w_d_pat, w_pat_rgb})
   );
`else
   assign w_req = w_den;
`endif

   // Raster counters and IDLE/RUN/DRAIN sequencing
   always_ff @(posedge i_clock) begin
      if (i_reset) begin
         r_state <= ST_IDLE;
         r_h     <= '0;
         r_v     <= '0;
         r_drain <= '0;
      end else begin
         case (r_state)
            ST_IDLE: begin
               r_h <= '0;
               r_v <= '0;
               if (i_enable) r_state <= ST_RUN;
            end
            ST_RUN: begin
               if (r_h == H_LAST12) begin
                  r_h <= '0;
                  if (r_v == V_LAST12) begin
                     r_v <= '0;
                     if (!i_enable) begin
                        r_state <= ST_DRAIN;
                        r_drain <= '0;
                     end
                  end else begin
                     r_v <= r_v + 12'd1;
                  end
               end else begin
                  r_h <= r_h + 12'd1;
               end
            end
            ST_DRAIN: begin
               r_h <= '0;
               r_v <= '0;
               if (r_drain == DRAIN_LAST) r_state <= ST_IDLE;
               else                       r_drain <= r_drain + 4'd1;
            end
            default: r_state <= ST_IDLE;
         endcase
      end
   end

   // Remember the coordinates of the last issued fetch
   always_ff @(posedge i_clock) begin
      if (i_reset) begin
         r_px <= '0;
         r_py <= '0;
      end else if (w_req) begin
         r_px <= r_h;
         r_py <= r_v;
      end
   end

   dvi_tx_delay_line #(.DEPTH(PIX_LAT), .WIDTH(4)) u_ctl_dly (
      .i_clock (i_clock),
      .i_reset (i_reset),
      .i_d     ({w_fs, w_vs, w_hs, w_den}),
      .o_q     ({w_d_fs, w_d_vs, w_d_hs, w_d_den})
   );

   assign w_tok = (w_d_hs ? CTRL_HSYNC : CTRL_NONE) | (w_d_vs ? CTRL_VSYNC : CTRL_NONE);

   // Choose the pixel source that lines up with the delayed data enable
   always_comb begin
      w_src_rgb = i_pix_rgb;
      w_src_ok  = i_pix_valid;
`ifdef DVI_TX_TEST_PATTERN_EN
      if (w_d_pat) begin
         w_src_rgb = w_pat_rgb;
         w_src_ok  = 1'b1;
      end
`endif
   end

   // Encoder-facing output register, with sticky underflow on a missing pixel
   always_ff @(posedge i_clock) begin
      if (i_reset) begin
         r_den  <= 1'b0;
         r_fs   <= 1'b0;
         r_ctrl <= CTRL_IDLE;
         r_rgb  <= '0;
         r_uf   <= 1'b0;
      end else begin
         r_den  <= w_d_den;
         r_fs   <= w_d_fs;
         r_ctrl <= w_tok ^ CTRL_IDLE;
         r_rgb  <= (w_d_den && w_src_ok) ? w_src_rgb : '0;
         if (w_d_den && !w_src_ok) r_uf <= 1'b1;
      end
   end

   assign o_pix_req     = w_req;
   assign o_pix_x       = w_req ? r_h : r_px;
   assign o_pix_y       = w_req ? r_v : r_py;
   assign o_enc_den     = r_den;
   assign o_enc_data_r  = r_rgb[23:16];
   assign o_enc_data_g  = r_rgb[15:8];
   assign o_enc_data_b  = r_rgb[7:0];
   assign o_enc_ctrl_b  = r_ctrl;
   assign o_enc_ctrl_g  = CTRL_NONE;
   assign o_enc_ctrl_r  = CTRL_NONE;
   assign o_frame_start = r_fs;
   assign o_underflow   = r_uf;
   assign o_busy        = (r_state != ST_IDLE);

endmodule

// File: tb/tb_dvi_tx_timing_ctrl.sv
// Bench for dvi_tx_timing_ctrl on an 8x6 raster (4/1/2/1 by 3/1/1/1), PIX_LAT=2.
// A second instance with HS_POL=0 shares all inputs to cover hsync polarity.
module tb_dvi_tx_timing_ctrl;

   localparam int HT    = 8;
   localparam int VT    = 6;
   localparam int LAT   = 2;
   localparam int FRAME = HT * VT;

   logic        clk = 1'b0;
   logic        rst, en, pv;
   logic [23:0] rgb;

   logic        a_req, a_den, a_fs, a_uf, a_busy;
   logic [11:0] a_x, a_y;
   logic [7:0]  a_db, a_dg, a_dr;
   logic [1:0]  a_cb, a_cg, a_cr;

   logic        n_req, n_den, n_fs, n_uf, n_busy;
   logic [11:0] n_x, n_y;
   logic [7:0]  n_db, n_dg, n_dr;
   logic [1:0]  n_cb, n_cg, n_cr;

   always #5 clk = ~clk;

   dvi_tx_timing_ctrl #(
      .H_ACTIVE(4), .H_FP(1), .H_SYNC(2), .H_BP(1),
      .V_ACTIVE(3), .V_FP(1), .V_SYNC(1), .V_BP(1),
      .HS_POL(1), .VS_POL(1), .PIX_LAT(LAT)
   ) u_dut (
      .i_clock(clk), .i_reset(rst), .i_enable(en),
`ifdef DVI_TX_TEST_PATTERN_EN
      .i_test_pattern(1'b0),
`endif
      .o_pix_req(a_req), .o_pix_x(a_x), .o_pix_y(a_y),
      .i_pix_rgb(rgb), .i_pix_valid(pv),
      .o_enc_den(a_den), .o_enc_data_b(a_db), .o_enc_data_g(a_dg), .o_enc_data_r(a_dr),
      .o_enc_ctrl_b(a_cb), .o_enc_ctrl_g(a_cg), .o_enc_ctrl_r(a_cr),
      .o_frame_start(a_fs), .o_underflow(a_uf), .o_busy(a_busy)
   );

   dvi_tx_timing_ctrl #(
      .H_ACTIVE(4), .H_FP(1), .H_SYNC(2), .H_BP(1),
      .V_ACTIVE(3), .V_FP(1), .V_SYNC(1), .V_BP(1),
      .HS_POL(0), .VS_POL(1), .PIX_LAT(LAT)
   ) u_dut_neg (
      .i_clock(clk), .i_reset(rst), .i_enable(en),
`ifdef DVI_TX_TEST_PATTERN_EN
      .i_test_pattern(1'b0),
`endif
      .o_pix_req(n_req), .o_pix_x(n_x), .o_pix_y(n_y),
      .i_pix_rgb(rgb), .i_pix_valid(pv),
      .o_enc_den(n_den), .o_enc_data_b(n_db), .o_enc_data_g(n_dg), .o_enc_data_r(n_dr),
      .o_enc_ctrl_b(n_cb), .o_enc_ctrl_g(n_cg), .o_enc_ctrl_r(n_cr),
      .o_frame_start(n_fs), .o_underflow(n_uf), .o_busy(n_busy)
   );

   int total = 0;
   int bad   = 0;

   // Reference model: run mode plus a linear position inside the frame
   typedef struct packed {logic den, hs, vs, fs;} exp_t;
   exp_t        pipe[$];
   int          m_mode;   // 0 idle, 1 run, 2 drain
   int          m_pos;
   int          m_dr;
   logic [11:0] m_px, m_py;
   logic        m_uf;
   logic        prev_val;
   logic [23:0] prev_rgb;
   logic        r1_req, r2_req;
   logic [11:0] r1_x, r1_y, r2_x, r2_y;
   bit          drop_pending;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      assert (got === exp) else begin
         bad++;
         $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   task automatic model_reset();
      m_mode = 0; m_pos = 0; m_dr = 0;
      m_px = '0; m_py = '0; m_uf = 1'b0;
      pipe.delete();
      repeat (LAT + 1) pipe.push_back('0);
   endtask

   // Check the current cycle, drive inputs, advance through one clock edge
   task automatic step(input logic t_rst, input logic t_en);
      exp_t        e, cur;
      int          h, v;
      logic [23:0] ed;
      logic [11:0] ex, ey;

      e = pipe.pop_front();
      if (e.den && !prev_val) m_uf = 1'b1;
      ed = (e.den && prev_val) ? prev_rgb : 24'h0;
      chk("enc_den",     32'(a_den), 32'(e.den));
      chk("enc_data_r",  32'(a_dr),  32'(ed[23:16]));
      chk("enc_data_g",  32'(a_dg),  32'(ed[15:8]));
      chk("enc_data_b",  32'(a_db),  32'(ed[7:0]));
      chk("enc_ctrl_b",  32'(a_cb),  32'({e.vs, e.hs}));
      chk("enc_ctrl_g",  32'(a_cg),  32'(0));
      chk("enc_ctrl_r",  32'(a_cr),  32'(0));
      chk("frame_start", 32'(a_fs),  32'(e.fs));
      chk("underflow",   32'(a_uf),  32'(m_uf));
      chk("ctrl_b_hsneg", 32'(n_cb), 32'({e.vs, ~e.hs}));

      h = m_pos % HT;
      v = m_pos / HT;
      cur.den = (m_mode == 1) && (h < 4) && (v < 3);
      cur.hs  = (m_mode == 1) && (h >= 5) && (h < 7);
      cur.vs  = (m_mode == 1) && (v == 4);
      cur.fs  = (m_mode == 1) && (m_pos == 0);
      ex = cur.den ? 12'(h) : m_px;
      ey = cur.den ? 12'(v) : m_py;
      chk("pix_req", 32'(a_req),  32'(cur.den));
      chk("pix_x",   32'(a_x),    32'(ex));
      chk("pix_y",   32'(a_y),    32'(ey));
      chk("busy",    32'(a_busy), 32'(m_mode != 0));
      m_px = ex;
      m_py = ey;
      pipe.push_back(cur);

      rst = t_rst;
      en  = t_en;
      if (r2_req) begin
         rgb = {8'($urandom), r2_y[7:0], r2_x[7:0]};
         pv  = 1'b1;
         if (drop_pending) begin
            pv = 1'b0;
            drop_pending = 1'b0;
         end
      end else begin
         rgb = 24'($urandom);
         pv  = 1'($urandom);
      end
      prev_rgb = rgb;
      prev_val = pv;
      r2_req = r1_req; r2_x = r1_x; r2_y = r1_y;
      r1_req = a_req;  r1_x = a_x;  r1_y = a_y;

      @(posedge clk);
      if (t_rst) begin
         model_reset();
      end else begin
         case (m_mode)
            0: if (t_en) begin m_mode = 1; m_pos = 0; end
            1: begin
               if (m_pos == FRAME - 1) begin
                  m_pos = 0;
                  if (!t_en) begin m_mode = 2; m_dr = 0; end
               end else begin
                  m_pos++;
               end
            end
            default: begin
               m_dr++;
               if (m_dr == LAT) m_mode = 0;
            end
         endcase
      end
      #1;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog got=timeout exp=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      rst = 1'b1; en = 1'b0; rgb = '0; pv = 1'b1;
      prev_val = 1'b1; prev_rgb = '0; drop_pending = 1'b0;
      r1_req = 1'b0; r2_req = 1'b0;
      r1_x = '0; r1_y = '0; r2_x = '0; r2_y = '0;
      model_reset();
      @(posedge clk);
      #1;

      // Reset held, then idle with enable low
      repeat (3) step(1'b1, 1'b0);
      repeat (3) step(1'b0, 1'b0);

      // Free-running frames
      repeat (2 * FRAME + 5) step(1'b0, 1'b1);

      // Enable dropped on line 1: frame completes, drains, returns to idle
      for (int i = 0; i < 2 * FRAME && !(m_mode == 1 && m_pos == HT); i++) step(1'b0, 1'b1);
      repeat (FRAME + 10) step(1'b0, 1'b0);

      // Restart and starve one active pixel
      repeat (20) step(1'b0, 1'b1);
      drop_pending = 1'b1;
      repeat (FRAME) step(1'b0, 1'b1);

      // Reset at h=2, v=1, then a clean restart
      for (int i = 0; i < 2 * FRAME && !(m_mode == 1 && m_pos == HT + 2); i++) step(1'b0, 1'b1);
      step(1'b1, 1'b1);
      repeat (3) step(1'b0, 1'b0);
      repeat (FRAME + 5) step(1'b0, 1'b1);

      // Randomised enable, occasional resets and pixel starvation
      for (int i = 0; i < 500; i++) begin
         if (($urandom % 40) == 0) drop_pending = 1'b1;
         step(($urandom % 97) == 0, ($urandom % 6) != 0);
      end
      repeat (FRAME + 5) step(1'b0, 1'b0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
